x_out_fifo_sync: RTL

- Single-clock, parametrised multi-channel output FIFO for the I/O-bank PHY datapath; successor to the fixed 10-lane, 8-entry out-FIFO primitive model.
- Generalises lane count, lane width, depth and almost-flag thresholds.
- Adds a runtime-selectable 2:1 serialising read mode, sticky overflow/underflow error flags and an occupancy count.
- Sits between fabric write logic and the OSERDES-facing lanes.

---
 rtl/x_out_fifo_sync.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/x_out_fifo_sync.sv
// Single-clock multi-lane output FIFO with optional 2:1 serialising read.
// Storage is not reset; pointers, count, phase, Q and sticky flags clear synchronously.
module x_out_fifo_sync #(
  parameter int    NUM_CH             = 10,
  parameter int    DIN_W              = 8,
  parameter int    DEPTH              = 8,
  parameter int    ALMOST_EMPTY_VALUE = 1,
  parameter int    ALMOST_FULL_VALUE  = 1,
  parameter string OUTPUT_DISABLE     = "FALSE"
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       WREN,
  input  logic [NUM_CH*DIN_W-1:0]    D,
  input  logic                       RDEN,
  input  logic                       SPLIT,
  output logic [NUM_CH*DIN_W-1:0]    Q,
  output logic                       EMPTY,
  output logic                       FULL,
  output logic                       ALMOSTEMPTY,
  output logic                       ALMOSTFULL,
  output logic                       OVERFLOW,
  output logic                       UNDERFLOW,
  output logic [$clog2(DEPTH):0]     COUNT
);

  // state  | meaning
  // PH_LO  | next split read returns the low half of each lane (or full word when SPLIT=0)
  // PH_HI  | low half already delivered; next split read returns the high half and pops

  localparam int W    = NUM_CH * DIN_W;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int HALF = DIN_W / 2;
  localparam bit OD   = (OUTPUT_DISABLE == "TRUE");

  localparam bit ATTR_OK = (NUM_CH >= 1) && (DIN_W >= 2) && (DIN_W % 2 == 0) &&
                           (DEPTH >= 4) && (DEPTH <= 64) && ((DEPTH & (DEPTH - 1)) == 0) &&
                           (ALMOST_EMPTY_VALUE >= 1) && (ALMOST_EMPTY_VALUE <= DEPTH - 2) &&
                           (ALMOST_FULL_VALUE >= 1) && (ALMOST_FULL_VALUE <= DEPTH - 2) &&
                           ((OUTPUT_DISABLE == "TRUE") || (OUTPUT_DISABLE == "FALSE"));

  if (!ATTR_OK) begin : g_attr_err
    $fatal(1, "x_out_fifo_sync: attribute error, illegal parameter value");
  end

  localparam logic [CW-1:0] FULL_TH = CW'(DEPTH);
  localparam logic [CW-1:0] AE_TH   = CW'(ALMOST_EMPTY_VALUE);
  localparam logic [CW-1:0] AF_TH   = CW'(DEPTH - ALMOST_FULL_VALUE);

  typedef enum logic {PH_LO = 1'b0, PH_HI = 1'b1} ph_t;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [W-1:0]  q_reg;
  logic [W-1:0]  rd_word;
  logic [W-1:0]  split_word;
  logic          ovf;
  logic          udf;
  logic          wr_ok;
  logic          rd_ok;
  logic          pop;
  ph_t           ph;
  ph_t           ph_nxt;

  assign EMPTY       = (count == '0);
  assign FULL        = (count == FULL_TH);
  assign ALMOSTEMPTY = (count <= AE_TH);
  assign ALMOSTFULL  = (count >= AF_TH);
  assign OVERFLOW    = ovf;
  assign UNDERFLOW   = udf;
  assign COUNT       = count;
  assign Q           = OD ? '0 : q_reg;

  assign wr_ok   = WREN & ~FULL;
  assign rd_ok   = RDEN & ~EMPTY;
  assign rd_word = mem[rd_ptr];

  always_comb begin
    ph_nxt = ph;
    pop    = 1'b0;
    if (rd_ok) begin
      if (!SPLIT) begin
        pop = 1'b1;
      end else if (ph == PH_LO) begin
        ph_nxt = PH_HI;
      end else begin
        ph_nxt = PH_LO;
        pop    = 1'b1;
      end
    end
  end

  always_comb begin
    count_nxt = count;
    case ({wr_ok, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Serialised lanes carry the selected half in the low bits, upper half zeroed.
  always_comb begin
    split_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      split_word[i*DIN_W +: HALF] = (ph == PH_HI) ? rd_word[i*DIN_W+HALF +: HALF]
                                                  : rd_word[i*DIN_W +: HALF];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) ph <= PH_LO;
    else       ph <= ph_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      q_reg  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      count <= count_nxt;
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (rd_ok) q_reg  <= SPLIT ? split_word : rd_word;
      if (WREN && FULL)  ovf <= 1'b1;
      if (RDEN && EMPTY) udf <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && wr_ok) mem[wr_ptr] <= D;
  end

endmodule
